// File: rtl/screen_pkg.sv
// Shared types for the full-screen image sequencer.
package screen_pkg;

  typedef enum logic [1:0] {
    SCR_START = 2'd0,
    SCR_GAME  = 2'd1,
    SCR_OVER  = 2'd2
  } screen_t;

  typedef enum logic [2:0] {
    START_HOLD,
    START_WAIT,
    FADE_OUT,
    FADE_IN,
    GAME,
    OVER_HOLD,
    OVER_WAIT
  } state_t;

  localparam logic [3:0] BRIGHT_MAX = 4'd15;

endpackage

// File: rtl/screen_sequencer_fade_unit.sv
// Frame prescaler plus brightness up/down counter for screen fades.
module fade_unit
  import screen_pkg::*;
#(
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir,
  input  logic       enable,
  input  logic       frame_start,
  output logic [3:0] brightness,
  output logic       at_min,
  output logic       at_max,
  output logic       step_tick
);

  localparam int SW =
    (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(FADE_STEP_FRAMES - 1);

  logic [SW-1:0] step_cnt;

  assign at_min    = (brightness == 4'd0);
  assign at_max    = (brightness == BRIGHT_MAX);
  assign step_tick = enable && frame_start && (step_cnt == STEP_LAST);

  // Prescaler idles at zero outside a fade so every fade starts aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt   <= '0;
      brightness <= BRIGHT_MAX;
    end else begin
      if (!enable)
        step_cnt <= '0;
      else if (frame_start)
        step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      if (step_tick) begin
        if (dir && !at_max)
          brightness <= brightness + 4'd1;
        else if (!dir && !at_min)
          brightness <= brightness - 4'd1;
      end
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Chooses the full-screen image and fades between screens at frame start.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int FADE_STEP_FRAMES = 4,
  parameter int HOLD_FRAMES      = 120
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       start_btn,
  input  logic       game_over,
  output logic [1:0] screen_sel,
  output logic [3:0] brightness,
  output logic       in_transition,
  output logic       game_active
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  state_t        state;
  screen_t       target;
  logic [HW-1:0] hold_cnt;
  logic          btn_prev;
  logic          btn_edge;
  logic          at_min;
  logic          at_max;
  logic          step_tick;
  logic          fade_en;
  logic          fade_dir;

  assign btn_edge = start_btn & ~btn_prev;
  assign fade_en  = (state == FADE_OUT) || (state == FADE_IN);
  assign fade_dir = (state == FADE_IN);

  fade_unit #(
    .FADE_STEP_FRAMES(FADE_STEP_FRAMES)
  ) u_fade (
    .clk        (vga_clk),
    .rst        (reset),
    .dir        (fade_dir),
    .enable     (fade_en),
    .frame_start(frame_start),
    .brightness (brightness),
    .at_min     (at_min),
    .at_max     (at_max),
    .step_tick  (step_tick)
  );

  // btn_prev resets high so a button held through reset is not an edge.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state         <= START_HOLD;
      target        <= SCR_START;
      screen_sel    <= SCR_START;
      in_transition <= 1'b0;
      game_active   <= 1'b0;
      hold_cnt      <= '0;
      btn_prev      <= 1'b1;
    end else begin
      btn_prev <= start_btn;
      unique case (state)
        START_HOLD, OVER_HOLD: begin
          if (frame_start) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= (state == START_HOLD) ? START_WAIT : OVER_WAIT;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        START_WAIT, OVER_WAIT: begin
          if (btn_edge) begin
            state         <= FADE_OUT;
            target        <= (state == START_WAIT) ? SCR_GAME : SCR_START;
            in_transition <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (step_tick && at_min) begin
            screen_sel <= target;
            state      <= FADE_IN;
          end
        end
        FADE_IN: begin
          if (step_tick && (at_max || brightness == BRIGHT_MAX - 4'd1)) begin
            in_transition <= 1'b0;
            unique case (target)
              SCR_GAME: begin
                state       <= GAME;
                game_active <= 1'b1;
              end
              SCR_OVER: state <= OVER_HOLD;
              default:  state <= START_HOLD;
            endcase
          end
        end
        GAME: begin
          if (game_over) begin
            state         <= FADE_OUT;
            target        <= SCR_OVER;
            game_active   <= 1'b0;
            in_transition <= 1'b1;
          end
        end
        default: state <= START_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed, table-driven checks of screen sequencing and fade timing.
module tb_screen_sequencer;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       start_btn;
  logic       game_over;
  logic [1:0] screen_sel;
  logic [3:0] brightness;
  logic       in_transition;
  logic       game_active;

  int compared   = 0;
  int mismatched = 0;

  localparam int OP_FRAMES = 0;
  localparam int OP_PRESS  = 1;
  localparam int OP_GOVER  = 2;

  typedef struct {
    int         op;
    int         n;
    logic [1:0] sel;
    logic [3:0] br;
    logic       tr;
    logic       ga;
  } vec_t;

  vec_t vecs[$];

  screen_sequencer #(
    .FADE_STEP_FRAMES(2),
    .HOLD_FRAMES     (3)
  ) dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .start_btn    (start_btn),
    .game_over    (game_over),
    .screen_sel   (screen_sel),
    .brightness   (brightness),
    .in_transition(in_transition),
    .game_active  (game_active)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string nm, input logic [1:0] s,
                       input logic [3:0] b, input logic t, input logic g);
    compared++;
    if ({screen_sel, brightness, in_transition, game_active} !==
        {s, b, t, g}) begin
      mismatched++;
      $display("FAIL %s: got sel=%0d br=%0d tr=%0b ga=%0b, expected sel=%0d br=%0d tr=%0b ga=%0b",
               nm, screen_sel, brightness, in_transition, game_active,
               s, b, t, g);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(negedge vga_clk);
      frame_start = 1'b0;
      @(negedge vga_clk);
      @(negedge vga_clk);
    end
  endtask

  task automatic press();
    start_btn = 1'b1;
    @(negedge vga_clk);
    start_btn = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic gover();
    game_over = 1'b1;
    @(negedge vga_clk);
    game_over = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic do_reset(input logic btn);
    start_btn = btn;
    reset     = 1'b1;
    repeat (3) @(negedge vga_clk);
    reset = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic add(input int op, input int n, input logic [1:0] s,
                     input logic [3:0] b, input logic t, input logic g);
    vec_t v;
    v.op = op; v.n = n; v.sel = s; v.br = b; v.tr = t; v.ga = g;
    vecs.push_back(v);
  endtask

  initial begin
    frame_start = 1'b0;
    game_over   = 1'b0;
    start_btn   = 1'b0;
    reset       = 1'b0;
    @(negedge vga_clk);

    // Start -> game -> over -> start, plus ignored events.
    add(OP_FRAMES, 1, 0, 15, 0, 0);
    add(OP_PRESS,  0, 0, 15, 0, 0);
    add(OP_FRAMES, 2, 0, 15, 0, 0);
    add(OP_PRESS,  0, 0, 15, 1, 0);
    add(OP_FRAMES, 1, 0, 15, 1, 0);
    add(OP_FRAMES, 1, 0, 14, 1, 0);
    add(OP_FRAMES, 28, 0, 0, 1, 0);
    add(OP_FRAMES, 1, 0, 0, 1, 0);
    add(OP_FRAMES, 1, 1, 0, 1, 0);
    add(OP_FRAMES, 2, 1, 1, 1, 0);
    add(OP_FRAMES, 27, 1, 14, 1, 0);
    add(OP_FRAMES, 1, 1, 15, 0, 1);
    add(OP_PRESS,  0, 1, 15, 0, 1);
    add(OP_FRAMES, 5, 1, 15, 0, 1);
    add(OP_GOVER,  0, 1, 15, 1, 0);
    add(OP_FRAMES, 2, 1, 14, 1, 0);
    add(OP_FRAMES, 30, 2, 0, 1, 0);
    add(OP_FRAMES, 30, 2, 15, 0, 0);
    add(OP_FRAMES, 1, 2, 15, 0, 0);
    add(OP_PRESS,  0, 2, 15, 0, 0);
    add(OP_FRAMES, 2, 2, 15, 0, 0);
    add(OP_GOVER,  0, 2, 15, 0, 0);
    add(OP_PRESS,  0, 2, 15, 1, 0);
    add(OP_FRAMES, 16, 2, 7, 1, 0);
    add(OP_GOVER,  0, 2, 7, 1, 0);
    add(OP_PRESS,  0, 2, 7, 1, 0);
    add(OP_FRAMES, 1, 2, 7, 1, 0);
    add(OP_FRAMES, 1, 2, 6, 1, 0);
    add(OP_FRAMES, 14, 0, 0, 1, 0);
    add(OP_FRAMES, 29, 0, 14, 1, 0);
    add(OP_FRAMES, 1, 0, 15, 0, 0);

    // Button held through reset is not an edge; nothing moves for 10 frames.
    do_reset(1'b1);
    check("reset_state", 0, 15, 0, 0);
    for (int i = 0; i < 10; i++) begin
      frames(1);
      check($sformatf("reset_idle_f%0d", i + 1), 0, 15, 0, 0);
    end

    do_reset(1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      unique case (vecs[i].op)
        OP_PRESS: press();
        OP_GOVER: gover();
        default:  frames(vecs[i].n);
      endcase
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].br,
            vecs[i].tr, vecs[i].ga);
    end

    // btn_edge coinciding with frame_start in START_WAIT.
    frames(3);
    check("simul_btn_wait", 0, 15, 0, 0);
    start_btn   = 1'b1;
    frame_start = 1'b1;
    @(negedge vga_clk);
    start_btn   = 1'b0;
    frame_start = 1'b0;
    @(negedge vga_clk);
    check("simul_btn_enter", 0, 15, 1, 0);
    frames(1);
    check("simul_btn_f1", 0, 15, 1, 0);
    frames(1);
    check("simul_btn_f2", 0, 14, 1, 0);
    frames(60);
    check("simul_btn_game", 1, 15, 0, 1);

    // game_over coinciding with frame_start in GAME.
    game_over   = 1'b1;
    frame_start = 1'b1;
    @(negedge vga_clk);
    game_over   = 1'b0;
    frame_start = 1'b0;
    @(negedge vga_clk);
    check("simul_go_enter", 1, 15, 1, 0);
    frames(1);
    check("simul_go_f1", 1, 15, 1, 0);
    frames(1);
    check("simul_go_f2", 1, 14, 1, 0);

    // Reset in the middle of a fade-in acts immediately.
    frames(30);
    check("midfade_swap", 2, 0, 1, 0);
    frames(10);
    check("midfade_b5", 2, 5, 1, 0);
    reset = 1'b1;
    #1;
    check("midfade_reset", 0, 15, 0, 0);
    @(negedge vga_clk);
    reset = 1'b0;
    @(negedge vga_clk);
    frames(4);
    check("post_reset_hold", 0, 15, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
